// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter.
//   state_e          - arbiter FSM state encoding (IDLE / ACCESS)
//   TIMEOUT_DEFAULT  - default wait limit, in cycles, for mem_ready
//   cnt_width()      - counter width able to hold a given limit without wrap
package mem_arb_pkg;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_ACCESS = 1'b1
   } state_e;

   localparam int unsigned TIMEOUT_DEFAULT = 16;

   // Width needed to represent 0..limit inclusive; never narrower than 1 bit.
   function automatic int unsigned cnt_width(input int unsigned limit);
      int unsigned w;
      w = $clog2(limit + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/arb_rr2.sv
// arb_rr2: two-requester round-robin pick with its priority pointer.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   req_i[1:0]    - request vector (bit 0 = CPU data port, bit 1 = loader/debug)
//   done_i        - a granted access completed this cycle (ack or timeout)
//   done_idx_i    - index of the requester whose access completed
//   gnt_vld_o_c   - combinational: at least one request present
//   gnt_idx_o_c   - combinational: index of the requester to grant
module arb_rr2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   input  logic       done_i,
   input  logic       done_idx_i,
   output logic       gnt_vld_o_c,
   output logic       gnt_idx_o_c
);

   logic ptr_q;
   logic ptr_d;

   // Pointer only matters on contention; a lone requester always wins.
   always_comb begin
      gnt_vld_o_c = |req_i;
      gnt_idx_o_c = 1'b0;
      case (req_i)
         2'b01:   gnt_idx_o_c = 1'b0;
         2'b10:   gnt_idx_o_c = 1'b1;
         2'b11:   gnt_idx_o_c = ptr_q;
         default: gnt_idx_o_c = 1'b0;
      endcase
   end

   // After a completed grant, prefer the other requester next time.
   always_comb begin
      ptr_d = ptr_q;
      if (done_i) begin
         ptr_d = ~done_idx_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter between two requesters sharing one
// single-outstanding memory port, with a ready timeout.
// Ports:
//   clk, rst                         - clock, asynchronous active-high reset
//   m{0,1}_req/we/addr/wdata/be      - requester command (held until ack)
//   m{0,1}_ack/err/rdata             - completion pulse, timeout flag, read data
//   mem_en/we/addr/wdata/be          - registered memory command, stable in ACCESS
//   mem_rdata, mem_ready             - memory read data and completion
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            m0_req,
   input  logic            m0_we,
   input  logic [AW-1:0]   m0_addr,
   input  logic [DW-1:0]   m0_wdata,
   input  logic [DW/8-1:0] m0_be,
   output logic            m0_ack,
   output logic            m0_err,
   output logic [DW-1:0]   m0_rdata,
   input  logic            m1_req,
   input  logic            m1_we,
   input  logic [AW-1:0]   m1_addr,
   input  logic [DW-1:0]   m1_wdata,
   input  logic [DW/8-1:0] m1_be,
   output logic            m1_ack,
   output logic            m1_err,
   output logic [DW-1:0]   m1_rdata,
   output logic            mem_en,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_be,
   input  logic [DW-1:0]   mem_rdata,
   input  logic            mem_ready
);

   localparam int unsigned BW = DW / 8;
   localparam int unsigned CW = cnt_width(TIMEOUT);

   state_e          state_q,     state_d;
   logic [CW-1:0]   cnt_q,       cnt_d;
   logic [CW-1:0]   cnt_inc;
   logic            gnt_q,       gnt_d;
   logic            mem_en_q,    mem_en_d;
   logic            mem_we_q,    mem_we_d;
   logic [AW-1:0]   mem_addr_q,  mem_addr_d;
   logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
   logic [BW-1:0]   mem_be_q,    mem_be_d;
   logic [1:0]      ack_q,       ack_d;
   logic [1:0]      err_q,       err_d;
   logic [DW-1:0]   rdata0_q,    rdata0_d;
   logic [DW-1:0]   rdata1_q,    rdata1_d;

   logic            gnt_vld;
   logic            gnt_idx;
   logic            done;

   logic            sel_we;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_wdata;
   logic [BW-1:0]   sel_be;

   arb_rr2 u_arb (
      .clk         (clk),
      .rst         (rst),
      .req_i       ({m1_req, m0_req}),
      .done_i      (done),
      .done_idx_i  (gnt_q),
      .gnt_vld_o_c (gnt_vld),
      .gnt_idx_o_c (gnt_idx)
   );

   // Command fields of the requester about to be granted.
   always_comb begin
      sel_we    = gnt_idx ? m1_we    : m0_we;
      sel_addr  = gnt_idx ? m1_addr  : m0_addr;
      sel_wdata = gnt_idx ? m1_wdata : m0_wdata;
      sel_be    = gnt_idx ? m1_be    : m0_be;
   end

   // Next-state and output logic; requester inputs are ignored in ACCESS.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cnt_inc     = cnt_q + CW'(1);
      gnt_d       = gnt_q;
      mem_en_d    = mem_en_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      ack_d       = 2'b00;
      err_d       = 2'b00;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;
      done        = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (gnt_vld) begin
               gnt_d       = gnt_idx;
               mem_en_d    = 1'b1;
               mem_we_d    = sel_we;
               mem_addr_d  = sel_addr;
               mem_wdata_d = sel_wdata;
               mem_be_d    = sel_be;
               state_d     = S_ACCESS;
            end
         end

         S_ACCESS: begin
            // A ready arriving on the timeout edge still completes normally.
            if (mem_ready) begin
               done          = 1'b1;
               mem_en_d      = 1'b0;
               cnt_d         = '0;
               state_d       = S_IDLE;
               ack_d[gnt_q]  = 1'b1;
               if (!mem_we_q) begin
                  if (gnt_q) begin
                     rdata1_d = mem_rdata;
                  end else begin
                     rdata0_d = mem_rdata;
                  end
               end
            end else if (cnt_inc == CW'(TIMEOUT)) begin
               done          = 1'b1;
               mem_en_d      = 1'b0;
               cnt_d         = '0;
               state_d       = S_IDLE;
               ack_d[gnt_q]  = 1'b1;
               err_d[gnt_q]  = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         default: begin
            state_d  = S_IDLE;
            mem_en_d = 1'b0;
            cnt_d    = '0;
         end
      endcase
   end

   // Reset clears everything immediately, aborting any access without an ack.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         gnt_q       <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         ack_q       <= 2'b00;
         err_q       <= 2'b00;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         gnt_q       <= gnt_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         ack_q       <= ack_d;
         err_q       <= err_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;
   assign m0_ack    = ack_q[0];
   assign m1_ack    = ack_q[1];
   assign m0_err    = err_q[0];
   assign m1_err    = err_q[1];
   assign m0_rdata  = rdata0_q;
   assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed plus randomized checks of mem_arbiter against a
// transaction-level model (round-robin order, latency, timeout, read data).
module tb_mem_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = DW / 8;
   localparam int          TO = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            m0_req, m0_we, m1_req, m1_we;
   logic [AW-1:0]   m0_addr, m1_addr;
   logic [DW-1:0]   m0_wdata, m1_wdata;
   logic [BW-1:0]   m0_be, m1_be;
   logic            m0_ack, m0_err, m1_ack, m1_err;
   logic [DW-1:0]   m0_rdata, m1_rdata;
   logic            mem_en, mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [BW-1:0]   mem_be;
   logic [DW-1:0]   mem_rdata;
   logic            mem_ready;

   mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
      .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
      .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;

   // Requester intent
   logic          r_req[2];
   logic          r_we[2];
   logic [AW-1:0] r_addr[2];
   logic [DW-1:0] r_wdata[2];
   logic [BW-1:0] r_be[2];
   int            rereq_left[2];

   // Reference model state
   int            m_ptr;
   logic [DW-1:0] m_rdata[2];

   logic          rd_fix_en;
   logic [DW-1:0] rd_fix;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      m0_req = r_req[0]; m0_we = r_we[0]; m0_addr = r_addr[0]; m0_wdata = r_wdata[0]; m0_be = r_be[0];
      m1_req = r_req[1]; m1_we = r_we[1]; m1_addr = r_addr[1]; m1_wdata = r_wdata[1]; m1_be = r_be[1];
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic rand_fields(input int i);
      r_we[i]    = 1'($urandom_range(0, 1));
      r_addr[i]  = AW'($urandom);
      r_wdata[i] = DW'($urandom);
      r_be[i]    = BW'($urandom);
   endtask

   task automatic model_reset();
      m_ptr = 0;
      m_rdata[0] = '0;
      m_rdata[1] = '0;
   endtask

   // Round-robin rule: contention goes to the pointer, otherwise to the lone requester.
   function automatic int pick(input logic [1:0] p, input int ptr);
      if (p == 2'b11) return ptr;
      return p[1] ? 1 : 0;
   endfunction

   function automatic int rand_delay();
      int r;
      r = int'($urandom_range(0, 9));
      if (r <= 5) return int'($urandom_range(0, 4));
      if (r <= 7) return (r == 6) ? TO - 2 : TO - 1;
      return int'($urandom_range(TO, TO + 2));
   endfunction

   // Serve every pending requester; d_fixed < 0 selects a random ready delay per access.
   task automatic serve(input logic [1:0] pend_in, input int d_fixed);
      logic [1:0]    pend;
      int            w, d, lat;
      logic          g_we, err_exp;
      logic [AW-1:0] g_addr;
      logic [DW-1:0] g_wdata, cur;
      logic [BW-1:0] g_be;
      logic [1:0]    exp_ack, exp_err;
      pend = pend_in;
      for (int i = 0; i < 2; i++) if (pend[i]) r_req[i] = 1'b1;
      drive();
      cur = '0;
      while (pend != 2'b00) begin
         w       = pick(pend, m_ptr);
         g_we    = r_we[w];
         g_addr  = r_addr[w];
         g_wdata = r_wdata[w];
         g_be    = r_be[w];
         d       = (d_fixed >= 0) ? d_fixed : rand_delay();
         lat     = (d < TO) ? d + 1 : TO;
         err_exp = (d >= TO);
         tick();
         chk("grant_cmd", {mem_en, mem_we, mem_be, mem_addr, mem_wdata},
             {1'b1, g_we, g_be, g_addr, g_wdata});
         chk("grant_noack", {m1_ack, m0_ack, m1_err, m0_err}, 4'b0);
         if (rereq_left[w] == 0 && $urandom_range(0, 3) == 0) begin
            r_req[w]   = 1'b0;
            r_we[w]    = ~r_we[w];
            r_addr[w]  = AW'($urandom);
            r_wdata[w] = DW'($urandom);
            drive();
         end
         for (int k = 1; k <= lat; k++) begin
            mem_ready = (k > d);
            cur       = rd_fix_en ? rd_fix : DW'($urandom);
            mem_rdata = cur;
            tick();
            if (k < lat) begin
               chk("hold_cmd", {mem_en, mem_we, mem_be, mem_addr, mem_wdata},
                   {1'b1, g_we, g_be, g_addr, g_wdata});
               chk("hold_noack", {m1_ack, m0_ack}, 2'b0);
            end
         end
         if (!g_we && !err_exp) m_rdata[w] = cur;
         exp_ack    = 2'b00;
         exp_ack[w] = 1'b1;
         exp_err    = err_exp ? exp_ack : 2'b00;
         chk("ack", {m1_ack, m0_ack}, exp_ack);
         chk("err", {m1_err, m0_err}, exp_err);
         chk("rdata", {m1_rdata, m0_rdata}, {m_rdata[1], m_rdata[0]});
         chk("en_fall", mem_en, 1'b0);
         m_ptr     = 1 - w;
         mem_ready = 1'b0;
         if (rereq_left[w] > 0) begin
            rereq_left[w]--;
            rand_fields(w);
            r_req[w] = 1'b1;
         end else begin
            r_req[w] = 1'b0;
            pend[w]  = 1'b0;
         end
         drive();
      end
      tick();
      chk("idle_after", {mem_en, m1_ack, m0_ack, m1_err, m0_err}, 5'b0);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      mem_ready = 1'b0;
      mem_rdata = '0;
      rd_fix_en = 1'b0;
      rd_fix    = '0;
      for (int i = 0; i < 2; i++) begin
         r_req[i] = 1'b0; r_we[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0; r_be[i] = '0;
         rereq_left[i] = 0;
      end
      drive();
      model_reset();
      repeat (2) @(negedge clk);

      // Reset values
      chk("rst_ctrl", {mem_en, mem_we, m1_ack, m0_ack, m1_err, m0_err}, 6'b0);
      chk("rst_cmd", {mem_be, mem_addr, mem_wdata}, '0);
      chk("rst_rdata", {m1_rdata, m0_rdata}, '0);
      rst = 1'b0;

      // Single CPU read with immediate ready
      r_we[0] = 1'b0; r_addr[0] = 32'h10; r_wdata[0] = '0; r_be[0] = 4'hF;
      rd_fix_en = 1'b1; rd_fix = 32'hDEADBEEF;
      serve(2'b01, 0);
      rd_fix_en = 1'b0;
      chk("beef", m0_rdata, 32'hDEADBEEF);

      // Simultaneous requests after reset; m0 re-requests after its ack
      pulse_reset();
      rand_fields(0); rand_fields(1);
      r_addr[0] = 32'h100; r_addr[1] = 32'h200;
      rereq_left[0] = 1;
      serve(2'b11, 0);

      // m1 write with three cycles of ready delay
      r_we[1] = 1'b1; r_addr[1] = 32'h40; r_wdata[1] = 32'h12345678; r_be[1] = 4'b0011;
      serve(2'b10, 3);

      // Timeout, then a normal access
      rand_fields(0); r_we[0] = 1'b0;
      serve(2'b01, 100);
      rand_fields(0);
      serve(2'b01, 0);

      // Reset in the middle of an m1 access, with the pointer at 1
      rand_fields(0);
      serve(2'b01, 0);
      rand_fields(1);
      r_req[1] = 1'b1;
      drive();
      tick();
      chk("pre_rst_en", mem_en, 1'b1);
      #2 rst = 1'b1;
      #1 chk("async_en", mem_en, 1'b0);
      chk("rst_noack", {m1_ack, m0_ack, m1_err, m0_err}, 4'b0);
      r_req[0] = 1'b0; r_req[1] = 1'b0;
      drive();
      @(negedge clk);
      chk("rst_hold", {mem_en, m1_ack, m0_ack}, 3'b0);
      rst = 1'b0;
      model_reset();
      rand_fields(0); rand_fields(1);
      r_addr[0] = 32'h300; r_addr[1] = 32'h400;
      serve(2'b11, 0);

      // Randomized traffic
      for (int n = 0; n < 40; n++) begin
         rand_fields(0); rand_fields(1);
         rereq_left[0] = ($urandom_range(0, 3) == 0) ? 1 : 0;
         rereq_left[1] = ($urandom_range(0, 3) == 0) ? 1 : 0;
         serve(2'($urandom_range(1, 3)), -1);
         repeat ($urandom_range(0, 2)) begin
            tick();
            chk("gap_idle", {mem_en, m1_ack, m0_ack}, 3'b0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32: address width.
REQ-002 SHALL have parameter DW, default 32: data width, a multiple of 8.
REQ-003 SHALL have parameter TIMEOUT, default 16: max cycles to wait for mem_ready.
REQ-004 SHALL have ports clk (in, 1, clock) and rst (in, 1, reset); one clock; reset is asynchronous and active-high.
REQ-005 SHALL have, for requester i in {0,1} (0 = CPU data port, 1 = loader/debug port): mi_req in 1, mi_we in 1, mi_addr in AW, mi_wdata in DW, mi_be in DW/8, mi_ack out 1, mi_err out 1, mi_rdata out DW.
REQ-006 SHALL have memory-side ports mem_en out 1, mem_we out 1, mem_addr out AW, mem_wdata out DW, mem_be out DW/8, mem_rdata in DW, mem_ready in 1.

Function
REQ-007 SHALL implement FSM states IDLE and ACCESS.
REQ-008 In IDLE with at least one mi_req high at a clk edge, SHALL grant one requester, register its we/addr/wdata/be onto mem_*, assert mem_en and enter ACCESS.
REQ-009 Arbitration SHALL be round-robin; a 1-bit priority pointer names the preferred requester and points to the other requester after each completed grant.
REQ-010 If only one requester is active, it SHALL be granted regardless of the pointer.
REQ-011 In ACCESS, mem_* outputs SHALL hold stable until completion, independent of changes on mi_*.
REQ-012 On a clk edge in ACCESS with mem_ready high, SHALL capture mem_rdata into the granted mi_rdata, pulse the granted mi_ack for exactly one cycle, deassert mem_en and return to IDLE.
REQ-013 Minimum latency: req sampled at edge N, mem_en high from N to N+1, mem_ready high before edge N+1, mi_ack high from N+1 to N+2.
REQ-014 A TIMEOUT-cycle counter SHALL run in ACCESS; when it reaches TIMEOUT without mem_ready, SHALL pulse mi_ack and mi_err together, leave mi_rdata unchanged, deassert mem_en and return to IDLE.
REQ-015 mi_err SHALL be high only in the mi_ack cycle of a timed-out access.
REQ-016 A requester SHALL hold mi_req and its fields until its mi_ack; a dropped mi_req mid-access SHALL NOT abort the access, and the ack SHALL still be pulsed.
REQ-017 The IDLE cycle after any ack SHALL be a free cycle: a new grant is taken no earlier than the edge after the ack edge, and the acked requester's still-high req is then arbitrated normally.
REQ-018 The non-granted requester SHALL see mi_ack low and mi_rdata unchanged.
REQ-019 For writes, mi_rdata SHALL NOT be updated.
REQ-020 The counter SHALL be wide enough for TIMEOUT with no wrap.

Reset
REQ-021 While rst is high, state SHALL be IDLE, the pointer 0, the counter 0, mem_en/mem_we/mi_ack/mi_err 0, and mem_addr/mem_wdata/mem_be/mi_rdata all-zero, asynchronously.
REQ-022 Reset asserted in ACCESS SHALL abort the access with no ack; mem_en SHALL fall without waiting for clk.

Structure
REQ-023 The FSM state encoding and the default TIMEOUT SHALL be in the shared package mem_arb_pkg.
REQ-024 The round-robin pick and pointer update SHALL be in one sub-module, arb_rr2.

Verification
REQ-025 m0 read addr 0x10, mem_ready tied 1, mem_rdata 0xDEADBEEF: m0_ack at edge N+1 with m0_rdata 0xDEADBEEF; m1_ack stays 0.
REQ-026 m0 and m1 requests in the same cycle after reset: m0 granted first; m1 granted at the edge after m0_ack; m0 re-requests: m0 granted after m1_ack.
REQ-027 m1 write addr 0x40, wdata 0x12345678, be 4'b0011, mem_ready delayed 3 cycles: mem_* stable for 4 cycles; single m1_ack; m1_rdata unchanged.
REQ-028 mem_ready held 0, TIMEOUT 16: ack and err pulse together 16 cycles after mem_en rises; FSM back to IDLE; next request is served normally.
REQ-029 rst pulsed mid-ACCESS: mem_en falls asynchronously, no ack is issued, and the pointer returns to 0.
